unidad_control_escalado: RTL
============================

Name: unidad_control_escalado

Overview:
- Sequencer that drives the datapath handshake FSM (iniciar / ocupado / listo) across a whole destination image.
- Walks destination pixels in batches of N_PAR.
- Per batch: presents dst_x/dst_y to the datapath address generator, requests one operation, captures the N_PAR results when the FSM reports listo, then writes them serially to destination memory.
- Sits between the top-level start/status registers and the datapath + destination RAM.

Parameters:
- ANCHO_DST, 64: destination width in pixels; must be a multiple of N_PAR (elaboration-time $error otherwise).
- ALTO_DST, 64: destination height in pixels.
- N_PAR, 4: pixels produced per datapath operation (parallel lanes).
- DATO_W, 8: pixel width in bits.
- ADDR_W, 16: destination memory address width.
- BASE_DST, 16'h0000: destination memory base address.
- CW, 8: coordinate width; must satisfy 2**CW >= max(ANCHO_DST, ALTO_DST).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- arranque  in  1  start a full-image pass (sampled only in S_INACTIVO).
- abortar  in  1  cancel the pass; highest priority after rst.
- iniciar  out  1  operation request to the datapath FSM (level, held until accepted).
- ocupado_dp  in  1  datapath FSM busy (in CARGA or CALCULO).
- listo_dp  in  1  datapath FSM results valid.
- resultados  in  N_PAR*DATO_W  datapath output bus; lane 0 in bits [DATO_W-1:0].
- dst_x  out  CW  x of lane 0 of the current batch.
- dst_y  out  CW  current destination row.
- mem_we  out  1  destination write valid.
- mem_listo  in  1  destination memory ready; a write completes on mem_we & mem_listo.
- mem_addr  out  ADDR_W  destination address.
- mem_dato  out  DATO_W  destination data.
- ocupado  out  1  pass in progress.
- hecho  out  1  one-cycle pulse when the pass completes.
- cuenta_ops  out  16  datapath operations completed in the current pass; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to S_INACTIVO.
  - All outputs are 0.
  - Counters (x, y, lane, address) are cleared.
- State machine states: S_INACTIVO, S_SOLICITA, S_ESPERA, S_ESCRIBE, S_FIN.
- S_INACTIVO:
  - arranque=1 → S_SOLICITA.
  - Load x=0, y=0, addr=BASE_DST, cuenta_ops=0.
  - iniciar is first high on the cycle after arranque.
- S_SOLICITA:
  - iniciar=1 and dst_x/dst_y are stable.
  - On ocupado_dp=1 → S_ESPERA; iniciar drops in the same transition.
  - Holding iniciar covers the datapath's step mode, where the request may wait many cycles for paso.
- S_ESPERA:
  - iniciar=0.
  - On listo_dp=1, register all N_PAR lanes of resultados, increment cuenta_ops, set lane=0, → S_ESCRIBE.
  - listo_dp is only honoured after ocupado_dp has been seen, so a stale listo from an earlier operation is never captured.
- S_ESCRIBE:
  - mem_we=1, mem_addr=addr, mem_dato=captured lane[lane].
  - On mem_listo=1: addr++ and lane++.
  - mem_listo=0 stalls; mem_we, mem_addr and mem_dato hold stable.
  - When the write of lane N_PAR-1 completes:
    - if x+N_PAR < ANCHO_DST: x += N_PAR, → S_SOLICITA.
    - else if y < ALTO_DST-1: x=0, y++, → S_SOLICITA.
    - else → S_FIN.
- Addressing: row-major and contiguous, so addr is a running counter (no multiplier).
- S_FIN: hecho=1 for exactly one cycle, then → S_INACTIVO.
- ocupado=1 in every state except S_INACTIVO.
- abortar=1 in any state except S_INACTIVO:
  - Next state is S_INACTIVO.
  - iniciar and mem_we are 0 from the next cycle.
  - No hecho pulse.
  - cuenta_ops holds its value.
  - An operation already accepted by the datapath completes there and is ignored.
- Ignored inputs:
  - arranque while ocupado=1.
  - arranque and abortar together in S_INACTIVO: abortar wins and the pass does not start.
- Unexpected listo_dp in S_SOLICITA or S_INACTIVO is ignored.
- Minimum latency per batch (free-running datapath, mem_listo=1): 1 cycle request + 2 cycles datapath + N_PAR write cycles.

Decomposition:
- Package escalado_pkg holds:
  - the estado_cu_t enum;
  - lane-slicing helper localparams (DATO_W-based lane offsets);
  - the shared ADDR_W default.
- One sub-module, escritor_carriles: the lane capture register plus the serial write and address counter with its valid/ready stall.
- The top module keeps the FSM and the x/y counters.

Test Plan:
- Full pass with ANCHO_DST=8, ALTO_DST=2, N_PAR=4, BASE_DST=16'h0100, model datapath (2-cycle ocupado, 1-cycle listo, lane i = 8'h10*op+i), mem_listo=1:
  - expect 4 operations and 16 writes to 16'h0100..16'h010F in order;
  - expect dst_x/dst_y sequence (0,0),(4,0),(0,1),(4,1);
  - expect hecho for 1 cycle after the last write and cuenta_ops=4.
- Step-mode datapath (ocupado asserted 5 cycles after iniciar):
  - iniciar stays high exactly until ocupado_dp=1;
  - exactly one capture per operation.
- Write backpressure, mem_listo low 3 cycles on lane 2 of batch 0:
  - mem_we, mem_addr=16'h0102 and its data held stable;
  - no skipped or duplicated address.
- abortar in S_ESCRIBE at lane 1:
  - mem_we=0 next cycle, ocupado=0, no hecho;
  - a new arranque restarts at addr 16'h0100, x=0, y=0.
- rst=1 mid-S_ESPERA: all outputs 0 at the next edge; listo_dp arriving afterwards causes no write.
- arranque pulsed while ocupado=1, and listo_dp injected during S_SOLICITA: both ignored; write sequence identical to the first scenario.

Source files
------------

// File: rtl/escalado_pkg.sv
// Shared types and lane-slicing helpers for the destination-image sequencer.
package escalado_pkg;

    // Sequencer states: idle, request, wait for results, serial write, done pulse.
    typedef enum logic [2:0] {
        S_INACTIVO = 3'd0,
        S_SOLICITA = 3'd1,
        S_ESPERA   = 3'd2,
        S_ESCRIBE  = 3'd3,
        S_FIN      = 3'd4
    } estado_cu_t;

    localparam int ADDR_W_DEF = 16;
    localparam int DATO_W_DEF = 8;
    localparam int N_PAR_DEF  = 4;

    // Bit offset of a lane inside the packed results bus (lane 0 in the LSBs).
    function automatic int desplazamiento_carril(input int carril, input int dato_w);
        return carril * dato_w;
    endfunction

endpackage

// File: rtl/escalado_escritor_carriles.sv
// Lane capture register plus the serial destination writer with its running
// address counter and valid/ready stall.
module escritor_carriles
    import escalado_pkg::*;
#(
    parameter int                N_PAR    = N_PAR_DEF,
    parameter int                DATO_W   = DATO_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] BASE_DST = {ADDR_W{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cargar_base,
    input  logic                    capturar,
    input  logic                    cancelar,
    input  logic [N_PAR*DATO_W-1:0] resultados,
    input  logic                    mem_listo,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATO_W-1:0]       mem_dato,
    output logic                    fin_lote
);

    localparam int                LANE_W        = (N_PAR > 1) ? $clog2(N_PAR) : 1;
    localparam logic [LANE_W-1:0] ULTIMO_CARRIL = LANE_W'(N_PAR - 1);
    localparam logic [LANE_W-1:0] UNO_CARRIL    = LANE_W'(1);
    localparam logic [ADDR_W-1:0] UNO_ADDR      = ADDR_W'(1);

    logic [DATO_W-1:0] carril_r [N_PAR];
    logic [LANE_W-1:0] carril_idx_r;
    logic [LANE_W-1:0] siguiente_idx_s;
    logic [DATO_W-1:0] dato_sig_s;
    logic              mem_we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATO_W-1:0] dato_r;
    logic              avanza_s;
    logic              ultimo_s;
    logic              fin_lote_s;

    // Decode the write handshake and pre-select the next lane to present.
    always_comb begin
        avanza_s   = mem_we_r & mem_listo;
        ultimo_s   = (carril_idx_r == ULTIMO_CARRIL);
        fin_lote_s = avanza_s & ultimo_s;
        if (ultimo_s) begin
            siguiente_idx_s = {LANE_W{1'b0}};
            dato_sig_s      = dato_r;
        end else begin
            siguiente_idx_s = carril_idx_r + UNO_CARRIL;
            dato_sig_s      = carril_r[siguiente_idx_s];
        end
    end

    // Capture all lanes at once, then step through them one accepted write at a time.
    // A stalled write (mem_listo low) simply leaves every register untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_r     <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            dato_r       <= {DATO_W{1'b0}};
            carril_idx_r <= {LANE_W{1'b0}};
            for (int i = 0; i < N_PAR; i++) begin
                carril_r[i] <= {DATO_W{1'b0}};
            end
        end else if (cancelar) begin
            mem_we_r <= 1'b0;
        end else if (cargar_base) begin
            addr_r   <= BASE_DST;
            mem_we_r <= 1'b0;
        end else if (capturar) begin
            for (int i = 0; i < N_PAR; i++) begin
                carril_r[i] <= resultados[desplazamiento_carril(i, DATO_W) +: DATO_W];
            end
            carril_idx_r <= {LANE_W{1'b0}};
            dato_r       <= resultados[DATO_W-1:0];
            mem_we_r     <= 1'b1;
        end else if (avanza_s) begin
            addr_r       <= addr_r + UNO_ADDR;
            carril_idx_r <= siguiente_idx_s;
            dato_r       <= dato_sig_s;
            mem_we_r     <= ~ultimo_s;
        end else begin
            mem_we_r <= mem_we_r;
        end
    end

    assign mem_we   = mem_we_r;
    assign mem_addr = addr_r;
    assign mem_dato = dato_r;
    assign fin_lote = fin_lote_s;

endmodule

// File: rtl/unidad_control_escalado.sv
// Sequencer that walks the destination image in batches of N_PAR pixels,
// handshaking with the datapath FSM and handing results to the lane writer.
module unidad_control_escalado
    import escalado_pkg::*;
#(
    parameter int                ANCHO_DST = 64,
    parameter int                ALTO_DST  = 64,
    parameter int                N_PAR     = N_PAR_DEF,
    parameter int                DATO_W    = DATO_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] BASE_DST  = {ADDR_W{1'b0}},
    parameter int                CW        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arranque,
    input  logic                    abortar,
    output logic                    iniciar,
    input  logic                    ocupado_dp,
    input  logic                    listo_dp,
    input  logic [N_PAR*DATO_W-1:0] resultados,
    output logic [CW-1:0]           dst_x,
    output logic [CW-1:0]           dst_y,
    output logic                    mem_we,
    input  logic                    mem_listo,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATO_W-1:0]       mem_dato,
    output logic                    ocupado,
    output logic                    hecho,
    output logic [15:0]             cuenta_ops
);

    if ((ANCHO_DST % N_PAR) != 32'sd0) begin : g_err_ancho
        $error("ANCHO_DST must be a multiple of N_PAR");
    end
    if (((32'sd1 << CW) < ANCHO_DST) || ((32'sd1 << CW) < ALTO_DST)) begin : g_err_cw
        $error("CW too narrow for the destination size");
    end

    localparam logic [CW:0]   PASO_X     = (CW+1)'(N_PAR);
    localparam logic [CW:0]   ANCHO_L    = (CW+1)'(ANCHO_DST);
    localparam logic [CW-1:0] Y_ULTIMA   = CW'(ALTO_DST - 1);
    localparam logic [CW-1:0] UNO_Y      = CW'(1);
    localparam logic [15:0]   CUENTA_MAX = 16'hFFFF;

    estado_cu_t    estado_r;
    logic [CW-1:0] x_r;
    logic [CW-1:0] y_r;
    logic          iniciar_r;
    logic          ocupado_r;
    logic          hecho_r;
    logic [15:0]   cuenta_r;
    logic [CW:0]   x_sig_s;
    logic          cargar_base_s;
    logic          capturar_s;
    logic          fin_lote_s;

    // Strobes towards the lane writer; abort suppresses both so nothing new starts.
    always_comb begin
        x_sig_s       = {1'b0, x_r} + PASO_X;
        cargar_base_s = 1'b0;
        capturar_s    = 1'b0;
        if (abortar) begin
            cargar_base_s = 1'b0;
            capturar_s    = 1'b0;
        end else begin
            cargar_base_s = (estado_r == S_INACTIVO) && arranque;
            capturar_s    = (estado_r == S_ESPERA) && listo_dp;
        end
    end

    // Main sequencer: state, x/y walk, request level, status outputs and op count.
    // S_ESPERA is only entered after ocupado_dp was seen, so any listo_dp taken
    // there belongs to the request just issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r  <= S_INACTIVO;
            x_r       <= {CW{1'b0}};
            y_r       <= {CW{1'b0}};
            iniciar_r <= 1'b0;
            ocupado_r <= 1'b0;
            hecho_r   <= 1'b0;
            cuenta_r  <= 16'h0000;
        end else if (abortar) begin
            estado_r  <= S_INACTIVO;
            iniciar_r <= 1'b0;
            ocupado_r <= 1'b0;
            hecho_r   <= 1'b0;
        end else begin
            case (estado_r)
                S_INACTIVO: begin
                    hecho_r <= 1'b0;
                    if (arranque) begin
                        estado_r  <= S_SOLICITA;
                        x_r       <= {CW{1'b0}};
                        y_r       <= {CW{1'b0}};
                        cuenta_r  <= 16'h0000;
                        iniciar_r <= 1'b1;
                        ocupado_r <= 1'b1;
                    end else begin
                        estado_r <= S_INACTIVO;
                    end
                end
                S_SOLICITA: begin
                    if (ocupado_dp) begin
                        estado_r  <= S_ESPERA;
                        iniciar_r <= 1'b0;
                    end else begin
                        iniciar_r <= 1'b1;
                    end
                end
                S_ESPERA: begin
                    if (listo_dp) begin
                        estado_r <= S_ESCRIBE;
                        if (cuenta_r != CUENTA_MAX) begin
                            cuenta_r <= cuenta_r + 16'h0001;
                        end else begin
                            cuenta_r <= cuenta_r;
                        end
                    end else begin
                        estado_r <= S_ESPERA;
                    end
                end
                S_ESCRIBE: begin
                    if (fin_lote_s) begin
                        if (x_sig_s < ANCHO_L) begin
                            x_r       <= x_sig_s[CW-1:0];
                            estado_r  <= S_SOLICITA;
                            iniciar_r <= 1'b1;
                        end else if (y_r < Y_ULTIMA) begin
                            x_r       <= {CW{1'b0}};
                            y_r       <= y_r + UNO_Y;
                            estado_r  <= S_SOLICITA;
                            iniciar_r <= 1'b1;
                        end else begin
                            estado_r <= S_FIN;
                            hecho_r  <= 1'b1;
                        end
                    end else begin
                        estado_r <= S_ESCRIBE;
                    end
                end
                S_FIN: begin
                    estado_r  <= S_INACTIVO;
                    hecho_r   <= 1'b0;
                    ocupado_r <= 1'b0;
                end
                default: begin
                    estado_r  <= S_INACTIVO;
                    iniciar_r <= 1'b0;
                    ocupado_r <= 1'b0;
                    hecho_r   <= 1'b0;
                end
            endcase
        end
    end

    escritor_carriles #(
        .N_PAR    (N_PAR),
        .DATO_W   (DATO_W),
        .ADDR_W   (ADDR_W),
        .BASE_DST (BASE_DST)
    ) u_escritor (
        .clk         (clk),
        .rst         (rst),
        .cargar_base (cargar_base_s),
        .capturar    (capturar_s),
        .cancelar    (abortar),
        .resultados  (resultados),
        .mem_listo   (mem_listo),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_dato    (mem_dato),
        .fin_lote    (fin_lote_s)
    );

    assign iniciar    = iniciar_r;
    assign dst_x      = x_r;
    assign dst_y      = y_r;
    assign ocupado    = ocupado_r;
    assign hecho      = hecho_r;
    assign cuenta_ops = cuenta_r;

endmodule
